// File: rtl/ifu.sv
// ifu - Instruction Fetch Unit.
//
// Generates the fetch PC, issues 16-bit word reads to instruction memory,
// buffers returned words in order and hands them to decode over a
// valid/ready handshake. Supports redirect (flush and refetch from a new
// PC) and halt (stop issuing new requests).
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   imem_req_o/addr_o     read request and word address to instruction memory
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order read response
//   instr_o, pc_o         head-of-buffer instruction and its address
//   instr_valid_o         instr_o/pc_o valid
//   instr_ready_i         decode accepts this cycle
//   redirect_i/pc_i       flush and restart fetch at redirect_pc_i
//   halt_i                suppress new requests while high
module ifu #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [15:0]       imem_rdata_i,
    output logic [15:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;      // PC of the next response that will be kept
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  discard_q;     // stale responses still to be dropped
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [15:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];

    logic [SUM_W-1:0]  inflight_sum;
    logic              credit_ok;
    logic              grant;
    logic              drop_rvalid;
    logic              keep_rvalid;
    logic              push;
    logic              pop;

    // FIFO pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (halt_i)  state_d = ST_HALT;
            ST_HALT:  if (!halt_i) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request stage: credit counts every word that may still occupy a FIFO
    // slot, so a push can never find the FIFO full. Only registered counters
    // feed the credit check; ready/rvalid never reach imem_req_o.
    assign inflight_sum = SUM_W'(outstanding_q) + SUM_W'(count_q) + SUM_W'(discard_q);
    assign credit_ok    = inflight_sum < SUM_W'(DEPTH);
    assign imem_req_o   = (state_q == ST_FETCH) && !halt_i && !redirect_i && credit_ok;
    assign imem_addr_o  = fetch_pc_q;
    assign grant        = imem_req_o && imem_gnt_i;

    // Response stage: an rvalid with nothing outstanding or pending discard
    // is a protocol error and matches neither term, so it is ignored.
    assign drop_rvalid  = imem_rvalid_i && (discard_q != '0);
    assign keep_rvalid  = imem_rvalid_i && (discard_q == '0) && (outstanding_q != '0);
    assign push         = keep_rvalid && !redirect_i;

    // Output stage: redirect masks valid so nothing is consumed while flushing.
    assign instr_valid_o = (count_q != '0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = fifo_instr[rd_ptr_q];
    assign pc_o          = fifo_pc[rd_ptr_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (redirect_i) begin
                // Everything still in flight belongs to the old stream. A kept
                // response arriving this cycle is consumed and thrown away.
                fetch_pc_q    <= redirect_pc_i;
                rsp_pc_q      <= redirect_pc_i;
                outstanding_q <= '0;
                discard_q     <= discard_q - CNT_W'(drop_rvalid) + outstanding_q
                                 + CNT_W'(grant) - CNT_W'(keep_rvalid);
                count_q       <= '0;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
            end else begin
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + 1'b1;
                end
                outstanding_q <= outstanding_q + CNT_W'(grant) - CNT_W'(keep_rvalid);
                discard_q     <= discard_q - CNT_W'(drop_rvalid);
                if (push) begin
                    fifo_instr[wr_ptr_q] <= imem_rdata_i;
                    fifo_pc[wr_ptr_q]    <= rsp_pc_q;
                    wr_ptr_q             <= ptr_inc(wr_ptr_q);
                    rsp_pc_q             <= rsp_pc_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule
